regfile_scoreboard: RTL and testbench

//   Parametrised multi-port register file for the pipelined MIPS datapath.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/regfile_pend_ctr.sv | 26 ++
 rtl/regfile_scoreboard.sv | 70 +++++++
 tb/tb_regfile_scoreboard.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared datapath widths, the hardwired-zero register index and ALU control encodings.
package mips_pkg;
    localparam int DATA_W_DEF  = 32;
    localparam int REG_NUM_DEF = 32;
    localparam int ADDR_W_DEF  = $clog2(REG_NUM_DEF);
    localparam int NUM_RD_DEF  = 2;
    localparam int PEND_W_DEF  = 2;
    localparam int REG_ZERO    = 0;
    typedef enum logic [3:0] {
        ALUC_ADD = 4'b0000,
        ALUC_SUB = 4'b0100,
        ALUC_AND = 4'b0001,
        ALUC_OR  = 4'b0101,
        ALUC_XOR = 4'b0010,
        ALUC_LUI = 4'b0110,
        ALUC_SLL = 4'b0011,
        ALUC_SRL = 4'b0111,
        ALUC_SRA = 4'b1111
    } aluc_e;
endpackage

// File: rtl/regfile_pend_ctr.sv
// regfile_pend_ctr: saturating pending-write counter for one register; clr wins, then a same-edge inc reloads 1.
module regfile_pend_ctr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         nz,
    output logic         full
);
    logic [W-1:0] cnt_nx;
    assign nz   = |cnt;
    assign full = &cnt;
    always_comb begin
        cnt_nx = clr                      ? W'(inc)      :
                 (inc && !dec && !full)   ? cnt + 1'b1   :
                 (dec && !inc && nz)      ? cnt - 1'b1   : cnt;
    end
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) cnt <= '0;
        else       cnt <= cnt_nx;
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port MIPS register file with per-register pending-write scoreboard; REGFILE_BYPASS_EN enables write-through.
module regfile_scoreboard
    import mips_pkg::*;
#(
    parameter  int DATA_W  = DATA_W_DEF,
    parameter  int REG_NUM = REG_NUM_DEF,
    parameter  int NUM_RD  = NUM_RD_DEF,
    parameter  int PEND_W  = PEND_W_DEF,
    localparam int ADDR_W  = $clog2(REG_NUM)
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ok,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     flush,
    output logic                     pend_any
);
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);
    logic [DATA_W-1:0]  regs [REG_NUM];
    logic [PEND_W-1:0]  cnt  [REG_NUM];
    logic [REG_NUM-1:0] nz, full;
    logic               iss_fire, wb_fire;
    assign wb_fire  = wb_en && wb_addr != ZERO;
    // A write-back retiring the same register frees a slot, so a full counter may still accept an issue.
    assign iss_ok   = !(full[iss_addr] && !(wb_fire && wb_addr == iss_addr));
    assign iss_fire = iss_en && iss_addr != ZERO && iss_ok;
    assign pend_any = |nz;
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) for (int k = 0; k < REG_NUM; k++) regs[k] <= '0;
        else if (wb_fire) regs[wb_addr] <= wb_data;
    end
    for (genvar r = 0; r < REG_NUM; r++) begin : g_ctr
        if (r == 0) begin : g_zero
            assign cnt[r]  = '0;
            assign nz[r]   = 1'b0;
            assign full[r] = 1'b0;
        end else begin : g_cnt
            regfile_pend_ctr #(.W(PEND_W)) u_ctr (
                .clk  (clk),
                .clrn (clrn),
                .inc  (iss_fire && iss_addr == ADDR_W'(r)),
                .dec  (wb_fire && wb_addr == ADDR_W'(r)),
                .clr  (flush),
                .cnt  (cnt[r]),
                .nz   (nz[r]),
                .full (full[r])
            );
        end
    end
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        logic hit;
        assign hit = wb_fire && wb_addr == a;
        assign rd_data[i*DATA_W +: DATA_W] = (a == ZERO) ? '0 : hit ? wb_data : regs[a];
        assign rd_busy[i] = a != ZERO && cnt[a] != '0 && !(hit && cnt[a] == PEND_W'(1));
`else
        assign rd_data[i*DATA_W +: DATA_W] = (a == ZERO) ? '0 : regs[a];
        assign rd_busy[i] = a != ZERO && cnt[a] != '0;
`endif
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed checks of reset, read/write, scoreboard saturation, flush and write-through.
module tb_regfile_scoreboard;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        clk = 1'b0, clrn = 1'b0;
    logic [4:0]  ra0 = '0, ra1 = '0, iss_addr = '0, wb_addr = '0;
    logic        iss_en = 1'b0, wb_en = 1'b0, flush = 1'b0;
    logic [31:0] wb_data = '0;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        iss_ok, pend_any;
    int          n_chk = 0, n_pass = 0;
    always #5 clk = ~clk;
    assign rd_addr = {ra1, ra0};
    regfile_scoreboard dut (
        .clk      (clk),
        .clrn     (clrn),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .iss_ok   (iss_ok),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .flush    (flush),
        .pend_any (pend_any)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        tick;
        wb_en = 1'b0;
        #1;
    endtask
    task automatic iss(input logic [4:0] a);
        iss_en = 1'b1; iss_addr = a;
        tick;
        iss_en = 1'b0;
        #1;
    endtask
    initial begin
        #2;
        chk("rst_data", rd_data[31:0], 32'h0);
        chk("rst_iss_ok", 32'(iss_ok), 32'd1);
        tick; tick;
        clrn = 1'b1;
        // write / read
        wb(5'd5, 32'hA00000AA);
        ra0 = 5'd5; ra1 = 5'd5; #1;
        chk("rd0_r5", rd_data[31:0], 32'hA00000AA);
        chk("rd1_r5", rd_data[63:32], 32'hA00000AA);
        wb(5'd0, 32'hFFFFFFFF);
        ra0 = 5'd0; #1;
        chk("rd_r0", rd_data[31:0], 32'h0);
        iss(5'd0);
        chk("busy_r0", 32'(rd_busy[0]), 32'd0);
        chk("pend_r0", 32'(pend_any), 32'd0);
        // async reset mid-cycle
        iss(5'd5);
        ra0 = 5'd5; iss_addr = 5'd5; #1;
        chk("pre_rst_busy", 32'(rd_busy[0]), 32'd1);
        chk("pre_rst_pend", 32'(pend_any), 32'd1);
        clrn = 1'b0; #1;
        chk("arst_data", rd_data[31:0], 32'h0);
        chk("arst_busy", 32'(rd_busy[0]), 32'd0);
        chk("arst_pend", 32'(pend_any), 32'd0);
        chk("arst_iss_ok", 32'(iss_ok), 32'd1);
        #1 clrn = 1'b1;
        tick;
        chk("post_rst_r5", rd_data[31:0], 32'h0);
        // saturation on r2
        ra0 = 5'd2;
        iss(5'd2); iss(5'd2); iss(5'd2);
        iss_addr = 5'd2; #1;
        chk("r2_full_iss_ok", 32'(iss_ok), 32'd0);
        iss(5'd2);
        wb(5'd2, 32'h22); chk("r2_busy_wb1", 32'(rd_busy[0]), 32'd1);
        wb(5'd2, 32'h22); chk("r2_busy_wb2", 32'(rd_busy[0]), 32'd1);
        wb(5'd2, 32'h22); chk("r2_busy_wb3", 32'(rd_busy[0]), 32'd0);
        chk("r2_pend_clear", 32'(pend_any), 32'd0);
        wb(5'd2, 32'h23); chk("r2_underflow", 32'(rd_busy[0]), 32'd0);
        chk("r2_data", rd_data[31:0], 32'h23);
        iss(5'd2); chk("r2_reissue", 32'(rd_busy[0]), 32'd1);
        wb(5'd2, 32'h24); chk("r2_back_zero", 32'(rd_busy[0]), 32'd0);
        // simultaneous issue + write-back on r3
        ra0 = 5'd3;
        iss(5'd3);
        iss_en = 1'b1; iss_addr = 5'd3; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
        tick;
        iss_en = 1'b0; wb_en = 1'b0; #1;
        chk("r3_same_busy", 32'(rd_busy[0]), 32'd1);
        wb(5'd3, 32'h33); chk("r3_cnt_was_1", 32'(rd_busy[0]), 32'd0);
        iss(5'd3); iss(5'd3); iss(5'd3);
        iss_en = 1'b1; iss_addr = 5'd3; #1;
        chk("r3_max_iss_ok", 32'(iss_ok), 32'd0);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h34; #1;
        chk("r3_max_wb_iss_ok", 32'(iss_ok), 32'd1);
        tick;
        iss_en = 1'b0; wb_en = 1'b0; #1;
        wb(5'd3, 32'h35); wb(5'd3, 32'h36);
        chk("r3_max_kept", 32'(rd_busy[0]), 32'd1);
        wb(5'd3, 32'h37);
        chk("r3_drained", 32'(rd_busy[0]), 32'd0);
        // flush
        iss(5'd4); iss(5'd7);
        flush = 1'b1;
        iss(5'd9);
        flush = 1'b0;
        ra0 = 5'd4; ra1 = 5'd7; #1;
        chk("flush_r4", 32'(rd_busy[0]), 32'd0);
        chk("flush_r7", 32'(rd_busy[1]), 32'd0);
        ra0 = 5'd9; #1;
        chk("flush_r9", 32'(rd_busy[0]), 32'd1);
        chk("flush_pend", 32'(pend_any), 32'd1);
        flush = 1'b1;
        wb(5'd8, 32'h88888888);
        flush = 1'b0;
        ra0 = 5'd8; ra1 = 5'd9; #1;
        chk("flush_wb_data", rd_data[31:0], 32'h88888888);
        chk("flush2_r9", 32'(rd_busy[1]), 32'd0);
        chk("flush2_pend", 32'(pend_any), 32'd0);
        // write-through
        wb(5'd6, 32'h11111111);
        iss(5'd6);
        ra1 = 5'd6;
        wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h60000066; #1;
        chk("byp_data", rd_data[63:32], BYP ? 32'h60000066 : 32'h11111111);
        chk("byp_busy", 32'(rd_busy[1]), BYP ? 32'd0 : 32'd1);
        tick;
        wb_en = 1'b0; #1;
        chk("byp_after_data", rd_data[63:32], 32'h60000066);
        chk("byp_after_busy", 32'(rd_busy[1]), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
